// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/MEM unified-memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_t;

    // Width of a counter that must reach n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (IF, MEM stage) and backing-memory buses of the port arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Handshake: every *_req is a level held until its *_ack; each *_ack is a
    // single-cycle pulse and the matching rdata is only meaningful in that cycle.
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Saturating wait counter; tc_o flags that an access has waited TIMEOUT-1 cycles.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = cnt_width(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o = (cnt_q == CW'(TIMEOUT - 1));

    // Clear has priority; holding at terminal count avoids wrap-around.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one variable-latency memory,
// with round-robin tie-break, pipeline stall and a timeout abort.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_port_arbiter_if.master  bus,
    output logic                stall_o,
    output logic                err_o,
    output logic                err_flag_o,
    output arb_state_t          dbg_state_o
);

    arb_state_t        state_q,     state_d;
    grant_t            last_q,      last_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q,    if_ack_d;
    logic              d_ack_q,     d_ack_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              err_q,       err_d;
    logic              err_flag_q,  err_flag_d;

    logic busy;
    logic wd_tc;

    assign busy = (state_q == IF_BUSY) || (state_q == D_BUSY);

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (!busy || bus.mem_ack),
        .en_i  (busy),
        .tc_o  (wd_tc)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        err_d       = 1'b0;
        err_flag_d  = err_flag_q;

        case (state_q)
            IDLE: begin
                // Data side wins a tie only when fetch had the previous grant.
                if (bus.d_req && (!bus.if_req || last_q == GNT_IF)) begin
                    state_d     = D_BUSY;
                    last_d      = GNT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                end else if (bus.if_req) begin
                    state_d     = IF_BUSY;
                    last_d      = GNT_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                end
            end

            IF_BUSY, D_BUSY: begin
                // A late ack in the terminal-count cycle still counts as success.
                if (bus.mem_ack || wd_tc) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    err_d     = !bus.mem_ack;
                    if (!bus.mem_ack) begin
                        err_flag_d = 1'b1;
                    end
                    if (state_q == IF_BUSY) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
                    end else begin
                        d_ack_d    = 1'b1;
                        d_rdata_d  = bus.mem_ack ? bus.mem_rdata : '0;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            last_q      <= GNT_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
            err_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
            err_flag_q  <= err_flag_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;

    // Combinational so the pipeline advances in the very cycle the ack appears.
    assign stall_o     = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);
    assign err_o       = err_q;
    assign err_flag_o  = err_flag_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a memory responder
// and a behavioural reference of the memory contents and arbitration rules.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall;
    logic       err;
    logic       err_flag;
    arb_state_t dbg_state;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus.master),
        .stall_o     (stall),
        .err_o       (err),
        .err_flag_o  (err_flag),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- memory responder ----------------
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } acc_t;

    acc_t        acc_log[$];
    logic [31:0] mem_store[logic [31:0]];
    int          mem_lat   = 0;
    bit          rnd_lat   = 0;
    bit          silent    = 0;
    bit          force_ack = 0;
    int          lat_cnt   = 0;
    bit          req_seen  = 0;
    int          high_cnt  = 0;
    int unsigned last_mem_ack_cyc = 0;
    acc_t        held;

    always begin
        @(negedge clk);
        bus.mem_ack   = force_ack;
        bus.mem_rdata = $urandom;
        if (rst || !bus.mem_req) begin
            req_seen = 0;
            lat_cnt  = 0;
        end else begin
            if (!req_seen) begin
                req_seen = 1;
                high_cnt = 0;
                lat_cnt  = 0;
                held     = '{bus.mem_addr, bus.mem_we, bus.mem_wdata};
                acc_log.push_back(held);
                if (rnd_lat) mem_lat = $urandom_range(0, 6);
            end else begin
                check("mem_bus_stable",
                      (bus.mem_addr === held.addr) && (bus.mem_we === held.we) &&
                      (bus.mem_wdata === held.wdata), 1'b1);
            end
            high_cnt++;
            if (!silent) begin
                if (lat_cnt == mem_lat) begin
                    bus.mem_ack = 1'b1;
                    if (held.we) begin
                        mem_store[held.addr] = held.wdata;
                    end else begin
                        bus.mem_rdata = mem_store.exists(held.addr) ? mem_store[held.addr]
                                                                    : init_word(held.addr);
                    end
                    last_mem_ack_cyc = cyc;
                end else begin
                    lat_cnt++;
                end
            end
        end
    end

    // ---------------- cycle monitor ----------------
    bit prev_if_ack = 0;
    bit prev_d_ack  = 0;
    int if_ack_cnt  = 0;
    int d_ack_cnt   = 0;
    int err_cnt     = 0;

    always begin
        @(posedge clk);
        #4;
        if (!rst) begin
            check("stall_formula", stall,
                  (bus.if_req & ~bus.if_ack) | (bus.d_req & ~bus.d_ack));
            check("ack_pulse_shape",
                  !(bus.if_ack && bus.d_ack) && !(bus.if_ack && prev_if_ack) &&
                  !(bus.d_ack && prev_d_ack) && (!err || bus.if_ack || bus.d_ack), 1'b1);
            if (bus.if_ack) if_ack_cnt++;
            if (bus.d_ack)  d_ack_cnt++;
            if (err)        err_cnt++;
        end
        prev_if_ack = !rst && bus.if_ack;
        prev_d_ack  = !rst && bus.d_ack;
    end

    // ---------------- driver tasks ----------------
    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data,
                         input bit exp_err, input string tag, output int unsigned ack_cyc);
        int start_idx;
        bit got;
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        start_idx   = acc_log.size();
        got         = 0;
        ack_cyc     = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.if_ack === 1'b1) got = 1;
        end
        check({tag, "_if_acked"}, got, 1'b1);
        if (got) begin
            ack_cyc = cyc;
            check({tag, "_if_rdata"}, bus.if_rdata, exp_data);
            check({tag, "_if_err"}, err, exp_err);
            if (!exp_err) check({tag, "_if_latency"}, cyc, last_mem_ack_cyc + 1);
            check({tag, "_if_fair"}, (acc_log.size() - start_idx) <= 2, 1'b1);
            check({tag, "_if_mem_addr"}, acc_log[acc_log.size()-1].addr, addr);
            check({tag, "_if_mem_we"}, acc_log[acc_log.size()-1].we, 1'b0);
        end
        bus.if_req = 1'b0;
    endtask

    task automatic data_access(input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                               input logic [31:0] exp_data, input bit exp_err, input string tag,
                               output int unsigned ack_cyc);
        int start_idx;
        bit got;
        @(negedge clk);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        start_idx   = acc_log.size();
        got         = 0;
        ack_cyc     = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.d_ack === 1'b1) got = 1;
        end
        check({tag, "_d_acked"}, got, 1'b1);
        if (got) begin
            ack_cyc = cyc;
            if (!we || exp_err) check({tag, "_d_rdata"}, bus.d_rdata, exp_data);
            check({tag, "_d_err"}, err, exp_err);
            if (!exp_err) check({tag, "_d_latency"}, cyc, last_mem_ack_cyc + 1);
            check({tag, "_d_fair"}, (acc_log.size() - start_idx) <= 2, 1'b1);
            check({tag, "_d_mem_addr"}, acc_log[acc_log.size()-1].addr, addr);
            check({tag, "_d_mem_we"}, acc_log[acc_log.size()-1].we, we);
            if (we) check({tag, "_d_mem_wdata"}, acc_log[acc_log.size()-1].wdata, wdata);
        end
        bus.d_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Expected memory contents of the data region as seen by the reference.
    logic [31:0] ref_mem[logic [31:0]];

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // ---------------- global time bound ----------------
    initial begin
        #400000;
        n_fail++;
        $display("FAIL global_timeout: observed=running expected=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "simulation time bound exceeded");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int unsigned c_d, c_f;
        int base, n0, e0;
        logic [31:0] wd;

        bus.if_req = 0; bus.if_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_state", dbg_state, IDLE);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_acks", {bus.if_ack, bus.d_ack}, 2'b00);
        check("rst_rdata", {bus.if_rdata, bus.d_rdata}, 64'h0);
        check("rst_err", {err, err_flag, stall}, 3'b000);
        rst = 1'b0;

        // Fetch alone, memory acks 2 cycles into the access
        mem_lat = 2;
        mem_store[32'h10] = 32'h2002_0005;
        n0 = if_ack_cnt;
        fetch(32'h10, 32'h2002_0005, 0, "t1", c_f);
        repeat (2) @(negedge clk);
        check("t1_one_pulse", if_ack_cnt - n0, 1);

        // Simultaneous requests right after reset: data store first
        do_reset();
        mem_lat = 1;
        base = acc_log.size();
        fork
            data_access(32'h80, 1'b1, 32'hDEAD_BEEF, 32'h0, 0, "t2", c_d);
            fetch(32'h20, init_word(32'h20), 0, "t2", c_f);
        join
        ref_mem[32'h80] = 32'hDEAD_BEEF;
        check("t2_n_access", acc_log.size() - base, 2);
        check("t2_first_addr", acc_log[base].addr, 32'h80);
        check("t2_first_we", acc_log[base].we, 1'b1);
        check("t2_first_wdata", acc_log[base].wdata, 32'hDEAD_BEEF);
        check("t2_second_addr", acc_log[base+1].addr, 32'h20);
        check("t2_ack_order", c_d < c_f, 1'b1);

        // Four back-to-back contended transactions alternate D, IF, D, IF
        base = acc_log.size();
        for (int k = 0; k < 2; k++) begin
            wd = $urandom;
            fork
                data_access(32'h100 + 8*k, 1'b1, wd, 32'h0, 0, "t3", c_d);
                fetch(32'h40 + 8*k, init_word(32'h40 + 8*k), 0, "t3", c_f);
            join
            ref_mem[32'h100 + 8*k] = wd;
        end
        check("t3_n_access", acc_log.size() - base, 4);
        check("t3_grant0", acc_log[base].addr,   32'h100);
        check("t3_grant1", acc_log[base+1].addr, 32'h40);
        check("t3_grant2", acc_log[base+2].addr, 32'h108);
        check("t3_grant3", acc_log[base+3].addr, 32'h48);
        data_access(32'h108, 1'b0, 32'h0, ref_read(32'h108), 0, "t3_rb", c_d);

        // Ack lands in the terminal-count cycle: success, no error
        mem_lat = TO - 1;
        fetch(32'h44, init_word(32'h44), 0, "t4a", c_f);
        check("t4a_err_flag", err_flag, 1'b0);

        // Memory never acks: abort after TIMEOUT cycles
        silent = 1;
        e0 = err_cnt;
        data_access(32'h140, 1'b0, 32'h0, 32'h0, 1, "t4b", c_d);
        check("t4b_req_high_cycles", high_cnt, TO);
        check("t4b_err_flag", err_flag, 1'b1);
        check("t4b_err_pulses", err_cnt - e0, 1);
        silent  = 0;
        mem_lat = 1;
        fetch(32'h4C, init_word(32'h4C), 0, "t4c", c_f);
        check("t4c_err_flag_sticky", err_flag, 1'b1);

        // Randomized concurrent traffic against the reference model
        rnd_lat = 1;
        fork
            begin
                for (int k = 0; k < 12; k++) begin
                    logic [31:0] fa;
                    int unsigned fc;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    fa = 32'h400 + 4 * $urandom_range(0, 15);
                    fetch(fa, init_word(fa), 0, "rnd", fc);
                end
            end
            begin
                for (int k = 0; k < 12; k++) begin
                    logic [31:0] da, dw;
                    bit          st;
                    int unsigned dc;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    da = 32'h800 + 4 * $urandom_range(0, 7);
                    st = ($urandom_range(0, 1) == 1);
                    dw = $urandom;
                    data_access(da, st, dw, ref_read(da), 0, "rnd", dc);
                    if (st) ref_mem[da] = dw;
                end
            end
        join
        rnd_lat = 0;

        // Asynchronous reset in the middle of a data access
        silent = 1;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h180; bus.d_wdata = 32'h1234_5678;
        repeat (3) @(negedge clk);
        check("t5_busy_before_rst", {bus.mem_req, dbg_state}, {1'b1, D_BUSY});
        check("t5_flag_before_rst", err_flag, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_mem_req", bus.mem_req, 1'b0);
        check("t5_rst_acks", {bus.if_ack, bus.d_ack, err}, 3'b000);
        check("t5_rst_err_flag", err_flag, 1'b0);
        check("t5_rst_state", dbg_state, IDLE);
        bus.d_req = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        silent = 0;
        @(posedge clk);
        #2 force_ack = 1'b1;
        @(posedge clk);
        #2 force_ack = 1'b0;
        @(negedge clk);
        check("t5_late_ack_ignored", {bus.mem_req, bus.if_ack, bus.d_ack, err, err_flag}, 5'b0);
        check("t5_late_ack_state", dbg_state, IDLE);
        mem_lat = 0;
        fetch(32'h60, init_word(32'h60), 0, "t5", c_f);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between two requesters: the instruction-fetch stage (read-only) and the data-memory stage (load/store).
- Sits between the pipeline (IF and MEM stages) and the backing memory.
- Serialises accesses through a small FSM and raises a pipeline stall while any request is outstanding.
- A watchdog aborts accesses the memory never acknowledges.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width.
- TIMEOUT, 64, cycles a memory access may stay un-acked before it is aborted (≥2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- if_req_i  in  1  fetch request; level, held until if_ack_o
- if_addr_i  in  ADDR_W  fetch address
- if_ack_o  out  1  one-cycle fetch completion pulse
- if_rdata_o  out  DATA_W  fetched word; valid when if_ack_o=1
- d_req_i  in  1  data request; level, held until d_ack_o
- d_we_i  in  1  1=store, 0=load
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_ack_o  out  1  one-cycle data completion pulse
- d_rdata_o  out  DATA_W  load data; valid when d_ack_o=1
- mem_req_o  out  1  memory request; held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_ack_i  in  1  memory completion pulse (one cycle)
- mem_rdata_i  in  DATA_W  memory read data; valid with mem_ack_i
- stall_o  out  1  freeze PC/IF_ID/ID_EX/EX_MEM/MEM_WB
- err_o  out  1  one-cycle pulse on timeout abort, coincident with the requester ack
- err_flag_o  out  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset, asynchronous, takes effect immediately even mid-access:
  - state=IDLE.
  - All outputs 0, including rdata outputs, mem_* outputs, err_flag_o.
  - last_grant=IF; wait counter=0.
- FSM states: IDLE, IF_BUSY, D_BUSY, DONE.
- IDLE:
  - Only d_req_i pending → D_BUSY.
  - Only if_req_i pending → IF_BUSY.
  - Both pending: round-robin tie-break. Grant the side not in last_grant, so the data side wins when last_grant=IF.
  - On grant, register address, we and wdata onto mem_*, set mem_req_o=1, record last_grant.
  - mem_req_o rises the cycle after the request is first seen in IDLE.
- IF_BUSY / D_BUSY:
  - mem_req_o and mem_* held stable; the wait counter increments each cycle.
  - On mem_ack_i: capture mem_rdata_i into the granted rdata output (if_rdata_o or d_rdata_o), pulse the granted ack for one cycle in the next cycle, drop mem_req_o, clear the counter, → DONE.
  - mem_we_o is forced 0 in IF_BUSY.
- Timeout:
  - Trigger: counter reaches TIMEOUT-1 with no mem_ack_i.
  - Drop mem_req_o, pulse the granted ack and err_o together, rdata=0, set err_flag_o, → DONE.
  - mem_ack_i in the same cycle as the timeout: ack wins, no error.
- DONE:
  - One bubble cycle, so a requester sees its ack before it is re-arbitrated.
  - Always → IDLE; no new grant in DONE.
- Ack latency: requester ack = mem_ack_i cycle + 1. Minimum round trip with a zero-wait memory = 3 cycles from request to ack.
- stall_o is combinational: (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o). It deasserts in the ack cycle so the pipeline advances exactly once.
- Requester drops req mid-access (protocol violation): the memory access completes normally, the ack pulse is still issued, and no abort occurs.
- mem_ack_i while in IDLE/DONE: ignored.
- rdata outputs hold their last value between acks.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, IF_BUSY, D_BUSY, DONE}.
  - grant enum {GNT_IF, GNT_D}.
  - Default widths and TIMEOUT constant.
- One natural sub-module: mem_arb_watchdog. Counter with clear, enable and terminal-count output, parameterised by TIMEOUT, asynchronous reset.

Test Plan:
- Fetch alone, memory acks 2 cycles after mem_req_o; if_addr=0x0000_0010, mem_rdata=0x2002_0005.
  - mem_addr_o=0x10, mem_we_o=0.
  - if_ack_o pulses once with if_rdata_o=0x2002_0005.
  - stall_o high from request until the ack cycle.
- Both requesters assert the same cycle after reset (last_grant=IF); data store addr 0x80, wdata 0xDEAD_BEEF.
  - Data granted first: mem_we_o=1, mem_wdata_o=0xDEADBEEF.
  - Fetch granted after DONE; acks in order d then if.
- Back-to-back both-pending for 4 transactions.
  - Grants alternate D, IF, D, IF.
  - No requester waits more than one other transaction.
- Memory never acks, TIMEOUT=8.
  - mem_req_o drops after 8 cycles high.
  - d_ack_o and err_o pulse together, d_rdata_o=0, err_flag_o stays 1.
  - A subsequent fetch still completes.
- rst_i asserted mid D_BUSY.
  - mem_req_o, acks and err_flag_o go 0 immediately (asynchronous).
  - After release, a new fetch completes normally.
  - A late mem_ack_i arriving in IDLE is ignored.
